// File: rtl/led_fx_pkg.sv
// Shared definitions for the LED effect driver: MODE encodings, the effect
// state enum and helpers that map between states and modes.
// Optional feature macro: LED_FX_CHASE_EN (adds the chase state).
package led_fx_pkg;

  localparam logic [1:0] MODE_STEADY = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_CHASE  = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  typedef enum logic [2:0] {
    ST_STEADY    = 3'd0,
    ST_BLINK_ON  = 3'd1,
    ST_BLINK_OFF = 3'd2,
`ifdef LED_FX_CHASE_EN
    ST_CHASE     = 3'd3,
`endif
    ST_OFF       = 3'd4
  } led_state_t;

  // Mode that a given state belongs to; both blink phases share one mode.
  function automatic logic [1:0] state_mode(input led_state_t s);
    case (s)
      ST_BLINK_ON, ST_BLINK_OFF: return MODE_BLINK;
`ifdef LED_FX_CHASE_EN
      ST_CHASE:                  return MODE_CHASE;
`endif
      ST_OFF:                    return MODE_OFF;
      default:                   return MODE_STEADY;
    endcase
  endfunction

  // State entered when switching into a mode.
  function automatic led_state_t entry_state(input logic [1:0] m);
    case (m)
      MODE_BLINK: return ST_BLINK_ON;
`ifdef LED_FX_CHASE_EN
      MODE_CHASE: return ST_CHASE;
`endif
      MODE_OFF:   return ST_OFF;
      default:    return ST_STEADY;
    endcase
  endfunction

endpackage

// File: rtl/led_fx_prescaler.sv
// Effect-tick prescaler: counts 0..PRESCALE_DIV-1 and flags the last count.
module led_fx_prescaler #(
  parameter int PRESCALE_DIV = 1000
) (
  input  logic PCLK,
  input  logic PRESET,
  output logic TICK
);

  localparam int CW = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running prescale counter, wrapping after the last count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else cnt <= cnt + CW'(1);
  end

  assign TICK = (cnt == LAST);

endmodule

// File: rtl/led_fx_driver.sv
// LED effect driver: PWM dimming, deferred pattern load, and steady / blink /
// chase / off effects stepped by a prescaled tick.
// Optional feature macro: LED_FX_CHASE_EN (chase effect; otherwise MODE=10
// is treated as steady).
module led_fx_driver
  import led_fx_pkg::*;
#(
  parameter int PRESCALE_DIV = 1000,
  parameter int BLINK_TICKS  = 250,
  parameter int PWM_BITS     = 8
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic [7:0]          LED_IN,
  input  logic                LED_VALID,
  input  logic [1:0]          MODE,
  input  logic [PWM_BITS-1:0] BRIGHT,
  output logic [7:0]          LED_PAD,
  output logic                TICK
);

  localparam int PW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(BLINK_TICKS - 1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PW-1:0]       phase_cnt;
  logic [7:0]          active;
  logic [7:0]          pending;
  logic                pending_flag;
  led_state_t          state;
  logic [1:0]          mode_eff;
  logic                pwm_wrap, pwm_on, phase_on, xfer, phase_last;

  led_fx_prescaler #(.PRESCALE_DIV(PRESCALE_DIV)) u_prescaler (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .TICK  (TICK)
  );

  assign pwm_wrap   = (pwm_cnt == '1);
  assign pwm_on     = (BRIGHT == '1) || (pwm_cnt < BRIGHT);
  assign xfer       = pwm_wrap && pending_flag;
  assign phase_last = (phase_cnt == PHASE_LAST);

  // Resolve the requested mode to one the build supports.
  // NOTE: give every combinational output a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    mode_eff = MODE;
`ifndef LED_FX_CHASE_EN
    if (MODE == MODE_CHASE) mode_eff = MODE_STEADY;
`endif
  end

  // LEDs are lit only in the states that show the pattern.
  always_comb begin
    phase_on = 1'b0;
    case (state)
      ST_STEADY, ST_BLINK_ON: phase_on = 1'b1;
`ifdef LED_FX_CHASE_EN
      ST_CHASE:               phase_on = 1'b1;
`endif
      default:                phase_on = 1'b0;
    endcase
  end

  // PWM counter, one step per clock.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) pwm_cnt <= '0;
    else pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

  // Pending pattern holder: latest strobe wins; a strobe coinciding with a
  // transfer survives for the next PWM wrap.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      pending      <= '0;
      pending_flag <= 1'b0;
    end else begin
      if (xfer) pending_flag <= 1'b0;
      if (LED_VALID) begin
        pending      <= LED_IN;
        pending_flag <= 1'b1;
      end
    end
  end

  // Effect FSM with phase counter and active pattern; a pattern transfer
  // overrides any rotation in the same cycle.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= ST_STEADY;
      phase_cnt <= '0;
      active    <= 8'h01;
    end else begin
      if (TICK) begin
        if (mode_eff != state_mode(state)) begin
          state     <= entry_state(mode_eff);
          phase_cnt <= '0;
        end else begin
          phase_cnt <= phase_last ? '0 : phase_cnt + PW'(1);
          if (phase_last) begin
            case (state)
              ST_BLINK_ON:  state  <= ST_BLINK_OFF;
              ST_BLINK_OFF: state  <= ST_BLINK_ON;
`ifdef LED_FX_CHASE_EN
              ST_CHASE:     active <= {active[6:0], active[7]};
`endif
              default:      ;
            endcase
          end
        end
      end
      if (xfer) begin
        active <= pending;
`ifdef LED_FX_CHASE_EN
        if (state == ST_CHASE) phase_cnt <= '0;
`endif
      end
    end
  end

  // Registered pad drive.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) LED_PAD <= '0;
    else LED_PAD <= active & {8{pwm_on & phase_on}};
  end

endmodule

// File: tb/tb_led_fx_driver.sv
// Self-checking bench for led_fx_driver (PRESCALE_DIV=4, BLINK_TICKS=2,
// PWM_BITS=4). The reference model tracks time since reset, the effect mode,
// ticks spent in it and a base pattern, and derives the displayed pattern
// arithmetically.
module tb_led_fx_driver;

  localparam int DIV = 4;
  localparam int BT  = 2;
  localparam int PB  = 4;
  localparam int PER = 1 << PB;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b0;
  logic [7:0]    LED_IN = '0;
  logic          LED_VALID = 1'b0;
  logic [1:0]    MODE = 2'b00;
  logic [PB-1:0] BRIGHT = '0;
  logic [7:0]    LED_PAD;
  logic          TICK;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  int         t;
  int         m_mode;
  int         m_cnt;
  logic [7:0] m_base;
  logic       m_pflag;
  logic [7:0] m_pval;
  logic [7:0] exp_pad;
  bit         saw_a5;

  led_fx_driver #(.PRESCALE_DIV(DIV), .BLINK_TICKS(BT), .PWM_BITS(PB)) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .LED_IN   (LED_IN),
    .LED_VALID(LED_VALID),
    .MODE     (MODE),
    .BRIGHT   (BRIGHT),
    .LED_PAD  (LED_PAD),
    .TICK     (TICK)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t, got, exp);
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] m_active();
    if (m_mode == 2) return rotl(m_base, (m_cnt / BT) % 8);
    return m_base;
  endfunction

  function automatic bit m_phase_on();
    case (m_mode)
      0, 2:    return 1'b1;
      1:       return ((m_cnt / BT) % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    t = 0; m_mode = 0; m_cnt = 0; m_base = 8'h01;
    m_pflag = 1'b0; m_pval = 8'h00; exp_pad = 8'h00;
  endtask

  // One clock: advance the model with the current inputs, then compare.
  task automatic cycle();
    int eff, old;
    logic [7:0] act;
    bit pon, tk, xf;
    act = m_active();
    pon = (BRIGHT == '1) || ((t % PER) < int'(BRIGHT));
    exp_pad = (pon && m_phase_on()) ? act : 8'h00;
    tk = (t % DIV) == DIV - 1;
    xf = ((t % PER) == PER - 1) && m_pflag;
    eff = int'(MODE);
`ifndef LED_FX_CHASE_EN
    if (eff == 2) eff = 0;
`endif
    old = m_mode;
    if (tk) begin
      if (eff != m_mode) begin
        m_base = act; m_mode = eff; m_cnt = 0;
      end else m_cnt++;
    end
    if (xf) begin
      m_base = m_pval;
      if (old == 2) m_cnt = 0;
      m_pflag = 1'b0;
    end
    if (LED_VALID) begin
      m_pval = LED_IN; m_pflag = 1'b1;
    end
    t++;
    @(posedge PCLK);
    @(negedge PCLK);
    check("pad", 32'(LED_PAD), 32'(exp_pad));
    check("tick", 32'(TICK), 32'((t % DIV) == DIV - 1));
    if (LED_PAD == 8'hA5) saw_a5 = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic load(input logic [7:0] p);
    LED_IN = p; LED_VALID = 1'b1;
    cycle();
    LED_VALID = 1'b0;
  endtask

  // Called just after a falling edge; asserts reset between edges.
  task automatic do_reset(input int hold);
    #2 PRESET = 1'b1;
    #1;
    check("rst_pad", 32'(LED_PAD), 32'h0);
    check("rst_tick", 32'(TICK), 32'h0);
    model_reset();
    repeat (hold) begin
      @(posedge PCLK);
      @(negedge PCLK);
      check("rst_hold_pad", 32'(LED_PAD), 32'h0);
    end
    PRESET = 1'b0;
  endtask

  initial begin
    int wait_n;
    model_reset();
    #1 PRESET = 1'b1;
    @(negedge PCLK);
    do_reset(2);

    // steady after reset: pattern 01, tick every 4 cycles
    MODE = 2'b00; BRIGHT = 4'hF;
    run(20);

    // reset mid-blink, then steady again
    MODE = 2'b01;
    run(13);
    do_reset(2);
    MODE = 2'b00; BRIGHT = 4'hF;
    run(12);

    // PWM duty with full pattern
    load(8'hFF);
    run(20);
    BRIGHT = 4'd4;
    run(32);
    BRIGHT = 4'd0;
    run(32);

    // deferred load: A5 overwritten by 3C before the wrap
    BRIGHT = 4'hF;
    while ((t % PER) != 2) cycle();
    saw_a5 = 1'b0;
    load(8'hA5);
    run(3);
    load(8'h3C);
    run(30);
    check("no_a5", 32'(saw_a5), 32'h0);

    // blink
    load(8'h0F);
    run(20);
    MODE = 2'b01;
    run(40);

    // chase (steady without the feature)
    MODE = 2'b00;
    load(8'h81);
    run(20);
    MODE = 2'b10;
    run(40);

    // strobe coinciding with the PWM wrap waits a full period
    MODE = 2'b00;
    run(8);
    while ((t % PER) != PER - 1) cycle();
    load(8'h55);
    wait_n = 0;
    while (LED_PAD != 8'h55 && wait_n < 40) begin
      cycle();
      wait_n++;
    end
    check("wrap_strobe_delay", 32'(wait_n), 32'd17);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) MODE = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) BRIGHT = PB'($urandom_range(0, PER - 1));
      LED_IN = 8'($urandom_range(0, 255));
      LED_VALID = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 699) == 0) begin
        LED_VALID = 1'b0;
        do_reset(1);
      end
      cycle();
    end
    LED_VALID = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
